multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Sequencing controller for the multi-cycle MIPS datapath: a Moore FSM that drives the shared instruction/data memory, instruction register, register file, single ALU and PC-source mux across several cycles per instruction. Supports R-type, lw, sw, beq, bne, addi and j. Waits on a memory ready handshake and resolves the PC write enable internally from the ALU zero flag. Outputs feed the existing ALUControl (aluop), register file and memory unchanged.

## Interface
- CNT_WIDTH, 32, width of the retired-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pcen  out  1  PC load enable (resolved)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread, memwrite  out  1 each  memory strobes
- irwrite  out  1  instruction register load
- regdst  out  1  0 = rt, 1 = rd
- memtoreg  out  1  0 = ALUOut, 1 = MDR
- regwrite  out  1  register file write
- alusrca  out  1  0 = PC, 1 = rs
- alusrcb  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- aluop  out  2  00 add, 01 sub, 10 funct
- pcsource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump address
- illegal  out  1  one-cycle pulse on an unsupported opcode
- retired  out  CNT_WIDTH  count of completed instructions

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00. irwrite=1 and pcen=1 only in the cycle mem_ready=1, then go to DECODE; otherwise hold.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC
  - 100011 / 101011 → MEMADR
  - 000100 / 000101 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - any other opcode → FETCH with illegal=1
- MEMADR: alusrca=1, alusrcb=10, aluop=00; next MEMRD (lw) or MEMWR (sw). The opcode is held stable by the IR.
- MEMRD: iord=1, memread=1; hold until mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1; then FETCH.
- MEMWR: iord=1, memwrite=1; hold until mem_ready, then FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10; then ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1; then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00; then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1; then FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsource=01. pcen = zero for beq, ~zero for bne. Then FETCH.
- JUMP: pcsource=10, pcen=1; then FETCH.
- Unlisted outputs are 0 in every state.
- retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP. It is not incremented for illegal opcodes and wraps modulo 2^CNT_WIDTH.

## Timing
- Outputs are combinational decodes of the state register, plus mem_ready (FETCH) and zero (BRANCH).
- Minimum cycles with mem_ready tied high: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3. Each wait cycle on mem_ready adds one cycle.
- Handshake: memread/memwrite/iord stay stable until the cycle in which mem_ready=1 is sampled. That cycle completes the access. mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Reset (rst_n low, asynchronous): state = FETCH, retired = 0. All outputs are forced to 0 while rst_n is low, including memread.
- Reset mid-access: the access is aborted immediately and no write strobe survives. After release, execution restarts with a FETCH in the first cycle.
- illegal is high only in the DECODE cycle; the next state is FETCH.

## Structure
- Shared package holds:
  - state encoding (4-bit localparams)
  - opcode constants
  - alusrcb, aluop and pcsource encodings
- The same package is imported by the datapath and the bench.
- Single module: state register, next-state logic, output decode and counter. No sub-module is needed; the opcode classification is a function in the package.

## Test plan
- lw with mem_ready low for 2 cycles in FETCH and 1 in MEMRD → state sequence FETCH×3, DECODE, MEMADR, MEMRD×2, MEMWB; regwrite=1, memtoreg=1 in MEMWB; retired 0→1.
- beq with zero=1 → pcen=1, pcsource=01 in BRANCH. Repeat with zero=0 → pcen=0. bne with zero=0 → pcen=1.
- R-type then addi back-to-back with mem_ready tied high → 8 cycles total; aluop=10 in EXEC, alusrcb=10 in ADDIEX; retired=2.
- opcode 111111 → illegal=1 for exactly one cycle in DECODE, next state FETCH, retired unchanged.
- rst_n pulsed low during MEMWR with memwrite=1 → memwrite drops in the same cycle; after release the next cycle is FETCH with memread=1 and retired=0.
- CNT_WIDTH=2, five j instructions → retired reads 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/multi_cycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencing controller: state
// encoding, opcodes, datapath mux/ALU encodings and opcode classification.
package multi_cycle_control_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_ADDIEX = 4'd8;
  localparam logic [3:0] S_ADDIWB = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  typedef enum logic [3:0] {
    FETCH  = S_FETCH,  DECODE = S_DECODE, MEMADR = S_MEMADR, MEMRD  = S_MEMRD,
    MEMWB  = S_MEMWB,  MEMWR  = S_MEMWR,  EXEC   = S_EXEC,   ALUWB  = S_ALUWB,
    ADDIEX = S_ADDIEX, ADDIWB = S_ADDIWB, BRANCH = S_BRANCH, JUMP   = S_JUMP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_MEM, CLS_BRANCH, CLS_ADDI, CLS_JUMP, CLS_ILLEGAL
  } op_class_e;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal;
  } ctrl_t;

  function automatic op_class_e classify_op(input logic [5:0] op);
    case (op)
      OP_RTYPE:       return CLS_RTYPE;
      OP_LW, OP_SW:   return CLS_MEM;
      OP_BEQ, OP_BNE: return CLS_BRANCH;
      OP_ADDI:        return CLS_ADDI;
      OP_J:           return CLS_JUMP;
      default:        return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath/memory signal bundle. The controller uses the
// master modport; the datapath side uses slave.
interface multi_cycle_control_if #(parameter int CNT_WIDTH = 32);
  logic [5:0]           opcode;
  logic                 zero;
  logic                 mem_ready;
  logic                 pcen;
  logic                 iord;
  logic                 memread;
  logic                 memwrite;
  logic                 irwrite;
  logic                 regdst;
  logic                 memtoreg;
  logic                 regwrite;
  logic                 alusrca;
  logic [1:0]           alusrcb;
  logic [1:0]           aluop;
  logic [1:0]           pcsource;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output pcen, iord, memread, memwrite, irwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, aluop, pcsource, illegal, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pcen, iord, memread, memwrite, irwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, aluop, pcsource, illegal, retired
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Moore sequencing FSM for the multi-cycle MIPS datapath with a memory ready
// handshake, internally resolved PC enable and a retired-instruction counter.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_cycle_control_if.master bus
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  ctrl_t                ctrl_s;
  ctrl_t                ctrl_out_s;
  logic                 retire_s;
  op_class_e            cls_s;

  assign cls_s = classify_op(bus.opcode);

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, output decode and retire detection
  always_comb begin
    state_d  = state_q;
    ctrl_s   = '0;
    retire_s = 1'b0;
    case (state_q)
      FETCH: begin
        ctrl_s.memread = 1'b1;
        ctrl_s.alusrcb = SRCB_FOUR;
        if (bus.mem_ready) begin
          ctrl_s.irwrite = 1'b1;
          ctrl_s.pcen    = 1'b1;
          state_d        = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        ctrl_s.alusrcb = SRCB_IMM_SH2;
        case (cls_s)
          CLS_RTYPE:  state_d = EXEC;
          CLS_MEM:    state_d = MEMADR;
          CLS_BRANCH: state_d = BRANCH;
          CLS_ADDI:   state_d = ADDIEX;
          CLS_JUMP:   state_d = JUMP;
          default: begin
            ctrl_s.illegal = 1'b1;
            state_d        = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = SRCB_IMM;
        if (bus.opcode == OP_SW) begin
          state_d = MEMWR;
        end else begin
          state_d = MEMRD;
        end
      end
      MEMRD: begin
        ctrl_s.iord    = 1'b1;
        ctrl_s.memread = 1'b1;
        if (bus.mem_ready) begin
          state_d = MEMWB;
        end else begin
          state_d = MEMRD;
        end
      end
      MEMWB: begin
        ctrl_s.memtoreg = 1'b1;
        ctrl_s.regwrite = 1'b1;
        state_d         = FETCH;
        retire_s        = 1'b1;
      end
      MEMWR: begin
        ctrl_s.iord     = 1'b1;
        ctrl_s.memwrite = 1'b1;
        if (bus.mem_ready) begin
          state_d  = FETCH;
          retire_s = 1'b1;
        end else begin
          state_d = MEMWR;
        end
      end
      EXEC: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = SRCB_RT;
        ctrl_s.aluop   = ALUOP_FUNCT;
        state_d        = ALUWB;
      end
      ALUWB: begin
        ctrl_s.regdst   = 1'b1;
        ctrl_s.regwrite = 1'b1;
        state_d         = FETCH;
        retire_s        = 1'b1;
      end
      ADDIEX: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = SRCB_IMM;
        state_d        = ADDIWB;
      end
      ADDIWB: begin
        ctrl_s.regwrite = 1'b1;
        state_d         = FETCH;
        retire_s        = 1'b1;
      end
      BRANCH: begin
        // Branch target was parked in ALUOut during DECODE; rs - rt sets zero
        ctrl_s.alusrca  = 1'b1;
        ctrl_s.alusrcb  = SRCB_RT;
        ctrl_s.aluop    = ALUOP_SUB;
        ctrl_s.pcsource = PCSRC_ALUOUT;
        ctrl_s.pcen     = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
        state_d         = FETCH;
        retire_s        = 1'b1;
      end
      JUMP: begin
        ctrl_s.pcsource = PCSRC_JUMP;
        ctrl_s.pcen     = 1'b1;
        state_d         = FETCH;
        retire_s        = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (retire_s) begin
      retired_d = retired_q + CNT_WIDTH'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // Reset kills every strobe immediately, including an in-flight memory write
  assign ctrl_out_s = rst_n ? ctrl_s : '0;

  assign bus.pcen     = ctrl_out_s.pcen;
  assign bus.iord     = ctrl_out_s.iord;
  assign bus.memread  = ctrl_out_s.memread;
  assign bus.memwrite = ctrl_out_s.memwrite;
  assign bus.irwrite  = ctrl_out_s.irwrite;
  assign bus.regdst   = ctrl_out_s.regdst;
  assign bus.memtoreg = ctrl_out_s.memtoreg;
  assign bus.regwrite = ctrl_out_s.regwrite;
  assign bus.alusrca  = ctrl_out_s.alusrca;
  assign bus.alusrcb  = ctrl_out_s.alusrcb;
  assign bus.aluop    = ctrl_out_s.aluop;
  assign bus.pcsource = ctrl_out_s.pcsource;
  assign bus.illegal  = ctrl_out_s.illegal;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench: per-instruction expected-cycle scripts drive a model
// that is compared against the controller every cycle, plus directed checks.
module tb_multi_cycle_control;
  import multi_cycle_control_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  multi_cycle_control_if #(.CNT_WIDTH(32)) bus ();
  multi_cycle_control_if #(.CNT_WIDTH(2))  bus2 ();

  multi_cycle_control #(.CNT_WIDTH(32)) u_dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
  multi_cycle_control #(.CNT_WIDTH(2))  u_dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

  localparam logic [1:0] K_PLAIN = 2'd0, K_FETCH = 2'd1, K_WAIT = 2'd2, K_BRANCH = 2'd3;

  typedef struct packed {
    logic [15:0] base;
    logic [1:0]  kind;
    logic        bne;
    logic        ret;
  } step_t;

  int          checks = 0;
  int          errors = 0;
  step_t       q[$];
  bit          rdy_script[$];
  logic [31:0] m_retired = 32'd0;
  logic [15:0] exp_ctrl = 16'd0;
  bit          exp_valid = 1'b0;
  bit          ready_tied = 1'b0;
  int          zero_force = -1;
  logic        last_branch_pcen = 1'b0;
  int          illegal_cycles = 0;
  bit          j_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {pcen,iord,memread,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,aluop,pcsource,illegal}
  function automatic logic [15:0] mk(input logic pc, io, rd, wr, ir, rdst, m2r, rw, sa,
                                     input logic [1:0] sb, aop, ps, input logic ill);
    return {pc, io, rd, wr, ir, rdst, m2r, rw, sa, sb, aop, ps, ill};
  endfunction

  function automatic logic [15:0] dut_ctrl();
    return {bus.pcen, bus.iord, bus.memread, bus.memwrite, bus.irwrite, bus.regdst,
            bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb, bus.aluop,
            bus.pcsource, bus.illegal};
  endfunction

  function automatic step_t stp(input logic [15:0] b, input logic [1:0] k, input logic bf, input logic r);
    step_t s;
    s.base = b; s.kind = k; s.bne = bf; s.ret = r;
    return s;
  endfunction

  // Expected cycle script of one instruction, straight from the per-state output rules
  task automatic build(input logic [5:0] op);
    logic ill;
    ill = !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J});
    q.delete();
    bus.opcode = op;
    q.push_back(stp(mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), K_FETCH, 1'b0, 1'b0));
    q.push_back(stp(mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,ill), K_PLAIN, 1'b0, 1'b0));
    case (op)
      OP_LW: begin
        q.push_back(stp(mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), K_PLAIN, 1'b0, 1'b0));
        q.push_back(stp(mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), K_WAIT,  1'b0, 1'b0));
        q.push_back(stp(mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), K_PLAIN, 1'b0, 1'b1));
      end
      OP_SW: begin
        q.push_back(stp(mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), K_PLAIN, 1'b0, 1'b0));
        q.push_back(stp(mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), K_WAIT,  1'b0, 1'b1));
      end
      OP_RTYPE: begin
        q.push_back(stp(mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), K_PLAIN, 1'b0, 1'b0));
        q.push_back(stp(mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), K_PLAIN, 1'b0, 1'b1));
      end
      OP_ADDI: begin
        q.push_back(stp(mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), K_PLAIN, 1'b0, 1'b0));
        q.push_back(stp(mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), K_PLAIN, 1'b0, 1'b1));
      end
      OP_BEQ, OP_BNE: begin
        q.push_back(stp(mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), K_BRANCH, op == OP_BNE, 1'b1));
      end
      OP_J: begin
        q.push_back(stp(mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), K_PLAIN, 1'b0, 1'b1));
      end
      default: ;
    endcase
  endtask

  task automatic do_cycle();
    logic  rdy, z;
    step_t s;
    @(negedge clk);
    if (rdy_script.size() > 0) rdy = rdy_script.pop_front();
    else if (ready_tied) rdy = 1'b1;
    else rdy = ($urandom_range(0, 2) != 0);
    if (zero_force < 0) z = 1'($urandom_range(0, 1));
    else z = zero_force[0];
    bus.mem_ready = rdy;
    bus.zero = z;
    #1;
    s = q[0];
    exp_ctrl = s.base;
    case (s.kind)
      K_FETCH:  begin exp_ctrl[15] = rdy; exp_ctrl[11] = rdy; end
      K_BRANCH: exp_ctrl[15] = z ^ s.bne;
      default: ;
    endcase
    exp_valid = 1'b1;
    #2;
    if (s.kind == K_BRANCH) last_branch_pcen = bus.pcen;
    if (bus.illegal) illegal_cycles++;
    @(posedge clk);
    exp_valid = 1'b0;
    if (s.kind == K_PLAIN || s.kind == K_BRANCH || rdy) begin
      s = q.pop_front();
      if (s.ret) m_retired = m_retired + 32'd1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, output int cyc);
    build(op);
    cyc = 0;
    while (q.size() > 0 && cyc < 40) begin
      do_cycle();
      cyc++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: opcode %0h still running after %0d cycles", op, cyc);
      q.delete();
    end
    #1;
  endtask

  // Every-cycle comparison of the DUT against the model expectation
  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      check("ctrl", {16'd0, dut_ctrl()}, {16'd0, exp_ctrl});
      check("retired", bus.retired, m_retired);
    end
  end

  // Narrow counter instance: back-to-back jumps wrap modulo 4
  initial begin
    int exp_w2[5] = '{1, 2, 3, 0, 1};
    bus2.opcode = OP_J;
    bus2.mem_ready = 1'b1;
    bus2.zero = 1'b0;
    @(posedge rst2_n);
    for (int k = 0; k < 5; k++) begin
      repeat (3) @(posedge clk);
      #1;
      check("retired_wrap", {30'd0, bus2.retired}, exp_w2[k]);
    end
    j_done = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, c1, c2;
    logic [31:0] r0;
    logic [5:0]  op;
    logic [5:0]  ops[8] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, 6'b111111};

    bus.opcode = OP_RTYPE;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    #12;
    check("reset_outputs", {16'd0, dut_ctrl()}, 32'd0);
    check("reset_memread", {31'd0, bus.memread}, 32'd0);
    check("reset_retired", bus.retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;

    // lw: two FETCH waits, one MEMRD wait
    rdy_script = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    run_instr(OP_LW, cyc);
    check("lw_cycles", cyc, 32'd8);
    check("lw_retired", bus.retired, 32'd1);

    ready_tied = 1'b1;
    zero_force = 1;
    run_instr(OP_BEQ, cyc);
    check("beq_taken_pcen", {31'd0, last_branch_pcen}, 32'd1);
    check("beq_cycles", cyc, 32'd3);
    zero_force = 0;
    run_instr(OP_BEQ, cyc);
    check("beq_not_taken_pcen", {31'd0, last_branch_pcen}, 32'd0);
    run_instr(OP_BNE, cyc);
    check("bne_taken_pcen", {31'd0, last_branch_pcen}, 32'd1);
    zero_force = 1;
    run_instr(OP_BNE, cyc);
    check("bne_not_taken_pcen", {31'd0, last_branch_pcen}, 32'd0);
    zero_force = -1;

    r0 = bus.retired;
    run_instr(OP_RTYPE, c1);
    run_instr(OP_ADDI, c2);
    check("rtype_addi_cycles", c1 + c2, 32'd8);
    check("rtype_addi_retired", bus.retired - r0, 32'd2);

    r0 = bus.retired;
    illegal_cycles = 0;
    run_instr(6'b111111, cyc);
    check("illegal_pulse", illegal_cycles, 32'd1);
    check("illegal_cycles", cyc, 32'd2);
    check("illegal_retired", bus.retired, r0);

    // Reset asserted while a store is waiting on memory
    ready_tied = 1'b0;
    build(OP_SW);
    rdy_script = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) do_cycle();
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    check("memwr_active", {31'd0, bus.memwrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_kills_memwrite", {31'd0, bus.memwrite}, 32'd0);
    check("reset_kills_memread", {31'd0, bus.memread}, 32'd0);
    check("reset_clears_retired", bus.retired, 32'd0);
    q.delete();
    m_retired = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_fetch", {31'd0, bus.memread}, 32'd1);
    check("post_reset_retired", bus.retired, 32'd0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom_range(0, 63));
        while (op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J})
          op = 6'($urandom_range(0, 63));
      end else begin
        op = ops[$urandom_range(0, 6)];
      end
      run_instr(op, cyc);
    end

    if (!j_done) @(posedge j_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
